// File: rtl/emulib_dma_axi_writer_if.sv
// Bundle of the DMA writer's job-setup handshakes, payload stream and AXI4 write master channels.
// "master" is the writer's view; "slave" is the view of whatever sits around it.
interface emulib_dma_axi_writer_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 64,
  parameter int COUNT_WIDTH = 16
);
  logic                    s_write_addr_valid;
  logic                    s_write_addr_ready;
  logic [ADDR_WIDTH-1:0]   s_write_addr;
  logic                    s_write_count_valid;
  logic                    s_write_count_ready;
  logic [COUNT_WIDTH-1:0]  s_write_count;
  logic                    s_write_data_valid;
  logic                    s_write_data_ready;
  logic [DATA_WIDTH-1:0]   s_write_data;

  logic                    m_axi_awvalid;
  logic                    m_axi_awready;
  logic [ADDR_WIDTH-1:0]   m_axi_awaddr;
  logic [7:0]              m_axi_awlen;
  logic [2:0]              m_axi_awsize;
  logic [1:0]              m_axi_awburst;
  logic                    m_axi_awlock;
  logic [3:0]              m_axi_awcache;
  logic [2:0]              m_axi_awprot;
  logic [3:0]              m_axi_awqos;
  logic [3:0]              m_axi_awregion;
  logic                    m_axi_wvalid;
  logic                    m_axi_wready;
  logic [DATA_WIDTH-1:0]   m_axi_wdata;
  logic [DATA_WIDTH/8-1:0] m_axi_wstrb;
  logic                    m_axi_wlast;
  logic                    m_axi_bvalid;
  logic                    m_axi_bready;
  logic [1:0]              m_axi_bresp;

  modport master (
    input  s_write_addr_valid, s_write_addr, s_write_count_valid, s_write_count,
           s_write_data_valid, s_write_data,
           m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_bresp,
    output s_write_addr_ready, s_write_count_ready, s_write_data_ready,
           m_axi_awvalid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
           m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awregion,
           m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_bready
  );

  modport slave (
    output s_write_addr_valid, s_write_addr, s_write_count_valid, s_write_count,
           s_write_data_valid, s_write_data,
           m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_bresp,
    input  s_write_addr_ready, s_write_count_ready, s_write_data_ready,
           m_axi_awvalid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
           m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awregion,
           m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_bready
  );
endinterface

// File: rtl/emulib_dma_axi_writer.sv
// Streams a job of COUNT 64-bit beats to memory as AXI4 INCR bursts, one burst in flight at a time,
// splitting on MAX_BURST and on 4 KiB page boundaries.
module emulib_dma_axi_writer #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 64,
  parameter int COUNT_WIDTH = 16,
  parameter int MAX_BURST   = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  emulib_dma_axi_writer_if.master        bus,
  output logic                           w_idle,
  output logic                           w_err
);
  localparam int BEAT_W = 9;
  localparam logic [BEAT_W-1:0] ONE_BEAT = BEAT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [COUNT_WIDTH-1:0] remain_q, remain_d;
  logic                   addr_cap_q, addr_cap_d;
  logic                   count_cap_q, count_cap_d;
  logic [BEAT_W-1:0]      beats_q, beats_d;
  logic [BEAT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic                   awvalid_q, awvalid_d;
  logic                   err_q, err_d;

  logic                   addr_hs, count_hs, aw_hs, w_hs, b_hs;
  logic [BEAT_W-1:0]      last_idx;
  logic                   unused_addr_lsbs;

  // Beats in the next burst: bounded by what is left, the burst cap and the room to the 4 KiB page end.
  function automatic logic [BEAT_W-1:0] burst_beats(input logic [ADDR_WIDTH-1:0]  a,
                                                    input logic [COUNT_WIDTH-1:0] rem);
    logic [31:0] n;
    logic [31:0] page;
    page = (32'd4096 - {20'd0, a[11:0]}) >> 3;
    n    = 32'(MAX_BURST);
    if (page < n) n = page;
    if (32'(rem) < n) n = 32'(rem);
    return n[BEAT_W-1:0];
  endfunction

  assign addr_hs  = bus.s_write_addr_valid  && bus.s_write_addr_ready;
  assign count_hs = bus.s_write_count_valid && bus.s_write_count_ready;
  assign aw_hs    = bus.m_axi_awvalid && bus.m_axi_awready;
  assign w_hs     = bus.m_axi_wvalid  && bus.m_axi_wready;
  assign b_hs     = bus.m_axi_bvalid  && bus.m_axi_bready;
  assign last_idx = beats_q - ONE_BEAT;

  assign unused_addr_lsbs = ^bus.s_write_addr[2:0];

  assign bus.s_write_addr_ready  = (state_q == S_IDLE) && !addr_cap_q;
  assign bus.s_write_count_ready = (state_q == S_IDLE) && !count_cap_q;

  assign bus.m_axi_awvalid  = awvalid_q;
  assign bus.m_axi_awaddr   = addr_q;
  assign bus.m_axi_awlen    = last_idx[7:0];
  assign bus.m_axi_awsize   = 3'd3;
  assign bus.m_axi_awburst  = 2'b01;
  assign bus.m_axi_awlock   = 1'b0;
  assign bus.m_axi_awcache  = 4'd0;
  assign bus.m_axi_awprot   = 3'd0;
  assign bus.m_axi_awqos    = 4'd0;
  assign bus.m_axi_awregion = 4'd0;

  // The payload stream is wired straight onto W, but only while a burst's data phase is open.
  assign bus.m_axi_wvalid       = (state_q == S_W) && bus.s_write_data_valid;
  assign bus.s_write_data_ready = (state_q == S_W) && bus.m_axi_wready;
  assign bus.m_axi_wdata        = (state_q == S_W) ? bus.s_write_data : '0;
  assign bus.m_axi_wstrb        = {(DATA_WIDTH/8){1'b1}};
  assign bus.m_axi_wlast        = (state_q == S_W) && (beat_cnt_q == last_idx);
  assign bus.m_axi_bready       = (state_q == S_B);

  assign w_idle = (state_q == S_IDLE) && !addr_cap_q && !count_cap_q;
  assign w_err  = err_q;

  // NOTE: every *_d gets its hold value first, so no path through this block can infer a latch;
  // blocking assignments here also let the B branch reuse the freshly computed addr_d/remain_d.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remain_d    = remain_q;
    addr_cap_d  = addr_cap_q;
    count_cap_d = count_cap_q;
    beats_d     = beats_q;
    beat_cnt_d  = beat_cnt_q;
    awvalid_d   = awvalid_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        if (addr_hs) begin
          addr_d     = {bus.s_write_addr[ADDR_WIDTH-1:3], 3'b000};
          addr_cap_d = 1'b1;
        end
        if (count_hs) begin
          remain_d    = bus.s_write_count;
          count_cap_d = 1'b1;
        end
        if (addr_cap_q && count_cap_q) begin
          addr_cap_d  = 1'b0;
          count_cap_d = 1'b0;
          if (remain_q != '0) begin
            state_d   = S_AW;
            awvalid_d = 1'b1;
            beats_d   = burst_beats(addr_q, remain_q);
          end
        end
      end

      S_AW: begin
        if (aw_hs) begin
          awvalid_d  = 1'b0;
          beat_cnt_d = '0;
          state_d    = S_W;
        end
      end

      S_W: begin
        if (w_hs) begin
          beat_cnt_d = beat_cnt_q + ONE_BEAT;
          if (bus.m_axi_wlast) state_d = S_B;
        end
      end

      S_B: begin
        if (b_hs) begin
          if (bus.m_axi_bresp != 2'b00) err_d = 1'b1;
          addr_d   = addr_q + ADDR_WIDTH'({beats_q, 3'b000});
          remain_d = remain_q - COUNT_WIDTH'(beats_q);
          if (remain_d != '0) begin
            state_d   = S_AW;
            awvalid_d = 1'b1;
            beats_d   = burst_beats(addr_d, remain_d);
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples the pre-edge values;
  // reset is synchronous and abandons any burst in flight without AXI clean-up.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remain_q    <= '0;
      addr_cap_q  <= 1'b0;
      count_cap_q <= 1'b0;
      beats_q     <= '0;
      beat_cnt_q  <= '0;
      awvalid_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remain_q    <= remain_d;
      addr_cap_q  <= addr_cap_d;
      count_cap_q <= count_cap_d;
      beats_q     <= beats_d;
      beat_cnt_q  <= beat_cnt_d;
      awvalid_q   <= awvalid_d;
      err_q       <= err_d;
    end
  end
endmodule
